// File: rtl/axil_master_pkg.sv
// Shared types and constants for the AXI4-Lite register master.
package axil_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic int timeout_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Saturating transaction watchdog: expires once the count reaches C_TIMEOUT_CYCLES-1.
module axil_watchdog
  import axil_master_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW      = timeout_cnt_width(C_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/axil_reg_master.sv
// AXI4-Lite initiator: one register command in, one AXI transaction out, one response back.
//   state      | meaning
//   ST_IDLE    | cmd_ready high, waiting for a command
//   ST_WRITE   | AWVALID/WVALID outstanding until both handshake
//   ST_WR_RESP | BREADY high, waiting for BVALID
//   ST_RD_ADDR | ARVALID outstanding
//   ST_RD_DATA | RREADY high, waiting for RVALID
//   ST_RESP    | rsp_valid high, fields held until rsp_ready
module axil_reg_master
  import axil_master_pkg::*;
#(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 12,
  parameter logic [31:0] C_BASE_ADDRESS     = 32'h00000000,
  parameter int          C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic                              busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [AW-1:0] BASE_LO = C_BASE_ADDRESS[AW-1:0];

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic            awvalid_q, awvalid_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic accept, active, expired, abort;

  assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign active = (state_q == ST_WRITE) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

  axil_watchdog #(
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (accept),
    .enable_i  (active),
    .expired_o (expired)
  );

  always_comb begin
    state_d       = state_q;
    awaddr_d      = awaddr_q;
    awvalid_d     = awvalid_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_write) begin
            state_d   = ST_WRITE;
            awaddr_d  = cmd_addr ^ BASE_LO;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RD_ADDR;
            araddr_d  = cmd_addr ^ BASE_LO;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        aw_done_d = aw_done_q | (awvalid_q & M_AXI_AWREADY);
        w_done_d  = w_done_q  | (wvalid_q  & M_AXI_WREADY);
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q  & ~M_AXI_WREADY;
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (bready_q && M_AXI_BVALID) begin
          state_d       = ST_RESP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          state_d   = ST_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (rready_q && M_AXI_RVALID) begin
          state_d       = ST_RESP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = M_AXI_RDATA;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hung slave: drop every AXI valid/ready together and report SLVERR.
    if (abort) begin
      state_d       = ST_RESP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = AXI_RESP_SLVERR;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      awaddr_q      <= '0;
      awvalid_q     <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= AXI_RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      awaddr_q      <= awaddr_d;
      awvalid_q     <= awvalid_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// Self-checking bench: AXI-Lite slave BFM with programmable latencies plus a word-array register model.
module tb_axil_reg_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axil_reg_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(12),
    .C_BASE_ADDRESS(32'h0), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int acc_cyc = 0;

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h0000CAFE : {16'hA5A5, 6'h0, 10'(i)};
  endfunction

  // ---------------- slave BFM ----------------
  int          aw_lat = 1, w_lat = 1, ar_lat = 1;
  bit          ar_never = 0, ovr_en = 0;
  logic [31:0] ovr_data = '0;
  logic [1:0]  bfm_rresp = 2'b00;
  logic [31:0] slave_mem [0:1023];
  logic        aw_got, w_got, ar_got;
  logic [11:0] aw_cap, ar_cap;
  logic [31:0] w_cap;
  logic [3:0]  s_cap;
  int          aw_wait, w_wait, ar_wait, aw_hs_n, w_hs_n, b_hs_n;

  always @(posedge clk) begin
    if (reset) begin
      awready <= 0; wready <= 0; bvalid <= 0; arready <= 0; rvalid <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_cap <= 0; ar_cap <= 0; w_cap <= 0; s_cap <= 0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      for (int i = 0; i < 1024; i++) slave_mem[i] <= init_val(i);
    end else begin
      if (AWVALID && awready) begin
        awready <= 0; aw_got <= 1; aw_cap <= AWADDR; aw_wait <= 0; aw_hs_n <= aw_hs_n + 1;
      end else if (AWVALID && !aw_got) begin
        if (aw_wait >= aw_lat - 1) awready <= 1; else aw_wait <= aw_wait + 1;
      end
      if (WVALID && wready) begin
        wready <= 0; w_got <= 1; w_cap <= WDATA; s_cap <= WSTRB; w_wait <= 0; w_hs_n <= w_hs_n + 1;
      end else if (WVALID && !w_got) begin
        if (w_wait >= w_lat - 1) wready <= 1; else w_wait <= w_wait + 1;
      end
      if (bvalid && BREADY) begin
        bvalid <= 0; aw_got <= 0; w_got <= 0; b_hs_n <= b_hs_n + 1;
      end else if (aw_got && w_got && !bvalid) begin
        bvalid <= 1; bresp <= 2'b00;
        for (int b = 0; b < 4; b++)
          if (s_cap[b]) slave_mem[aw_cap[11:2]][8*b +: 8] <= w_cap[8*b +: 8];
      end
      if (ARVALID && arready) begin
        arready <= 0; ar_got <= 1; ar_cap <= ARADDR; ar_wait <= 0;
      end else if (ARVALID && !ar_got && !ar_never) begin
        if (ar_wait >= ar_lat - 1) arready <= 1; else ar_wait <= ar_wait + 1;
      end
      if (rvalid && RREADY) begin
        rvalid <= 0; ar_got <= 0;
      end else if (ar_got && !rvalid) begin
        rvalid <= 1; rresp <= bfm_rresp;
        rdata  <= ovr_en ? ovr_data : slave_mem[ar_cap[11:2]];
      end
    end
  end

  // ---------------- protocol monitor: VALID held and payload stable until handshake ----------------
  bit          mon_en = 0, p_ok = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [11:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  int          viol = 0;

  always @(posedge clk) begin
    if (p_ok && mon_en && !reset) begin
      if (p_awv && !p_awr && (!AWVALID || AWADDR !== p_awaddr)) viol++;
      if (p_wv  && !p_wr  && (!WVALID  || WDATA  !== p_wdata))  viol++;
      if (p_arv && !p_arr && (!ARVALID || ARADDR !== p_araddr)) viol++;
    end
    p_ok = mon_en && !reset;
    p_awv = AWVALID; p_awr = awready; p_awaddr = AWADDR;
    p_wv  = WVALID;  p_wr  = wready;  p_wdata  = WDATA;
    p_arv = ARVALID; p_arr = arready; p_araddr = ARADDR;
  end

  // ---------------- reference register model ----------------
  logic [31:0] ref_mem [0:1023];

  task automatic init_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic ref_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic issue(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, output bit ok);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1; ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got, output int lat);
    got = 0; lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid === 1'b1) begin got = 1; lat = cyc - acc_cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic take_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic to);
    rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    init_ref();
    repeat (3) @(negedge clk);
    total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else passed++;
    total++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0)
      $display("FAIL reset_axi_valid: got %b want 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY}); else passed++;
    total++; if ({AWADDR, ARADDR, WDATA, WSTRB} !== 60'h0)
      $display("FAIL reset_axi_payload: got %h want 0", {AWADDR, ARADDR, WDATA, WSTRB}); else passed++;
    total++; if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy} !== 37'h0)
      $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy}); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready); else passed++;
    mon_en = 1;
  endtask

  task automatic test_write_basic();
    bit ok, got; int lat; logic [31:0] rd; logic [1:0] rs; logic to;
    issue(1'b1, 12'h010, 32'h12345678, 4'hF, ok);
    total++; if (!ok) $display("FAIL wr_accept: cmd_ready never high"); else passed++;
    total++; if ({AWVALID, WVALID} !== 2'b11) $display("FAIL wr_aw_w_together: got %b want 11", {AWVALID, WVALID}); else passed++;
    total++; if (AWADDR !== 12'h010) $display("FAIL wr_awaddr: got %h want 010", AWADDR); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else passed++;
    wait_valid(got, lat);
    total++; if (!got) $display("FAIL wr_rsp_timeout_bound: no rsp_valid"); else passed++;
    total++; if (lat != 4) $display("FAIL wr_latency: got %0d want 4", lat); else passed++;
    total++; if (w_cap !== 32'h12345678) $display("FAIL wr_bfm_wdata: got %h want 12345678", w_cap); else passed++;
    take_rsp(rd, rs, to);
    ref_write(12'h010, 32'h12345678, 4'hF);
    total++; if ({rd, rs, to} !== 35'h0) $display("FAIL wr_rsp_fields: got rd=%h rs=%b to=%b want 0", rd, rs, to); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready_after_rsp: got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_read_basic();
    bit ok, got; int lat; logic [31:0] rd; logic [1:0] rs; logic to;
    issue(1'b0, 12'h000, 32'h0, 4'h0, ok);
    total++; if (ARVALID !== 1'b1 || ARADDR !== 12'h000) $display("FAIL rd_arvalid: got v=%b a=%h want 1/000", ARVALID, ARADDR); else passed++;
    wait_valid(got, lat);
    total++; if (!got || lat != 4) $display("FAIL rd_latency: got %0d want 4", lat); else passed++;
    take_rsp(rd, rs, to);
    total++; if (rd !== 32'h0000CAFE || rs !== 2'b00 || to !== 1'b0)
      $display("FAIL rd_cafe: got rd=%h rs=%b to=%b want 0000cafe/00/0", rd, rs, to); else passed++;
    ovr_en = 1; ovr_data = 32'hDEADBEEF;
    issue(1'b0, 12'hFFC, 32'h0, 4'h0, ok);
    wait_valid(got, lat);
    take_rsp(rd, rs, to);
    ovr_en = 0;
    total++; if (!got || rd !== 32'hDEADBEEF || rs !== 2'b00)
      $display("FAIL rd_unmapped: got rd=%h rs=%b want deadbeef/00", rd, rs); else passed++;
  endtask

  task automatic test_write_skew(input int awl, input int wl);
    bit ok, got; int lat, b0, a0, w0; logic [31:0] rd; logic [1:0] rs; logic to;
    logic [31:0] d; logic [11:0] a;
    d = $urandom; a = 12'($urandom_range(0, 63) * 4);
    aw_lat = awl; w_lat = wl;
    b0 = b_hs_n; a0 = aw_hs_n; w0 = w_hs_n;
    issue(1'b1, a, d, 4'hF, ok);
    repeat (3) @(negedge clk);
    total++; if ({AWVALID, WVALID} !== ((awl < wl) ? 2'b01 : 2'b10))
      $display("FAIL skew_%0d_%0d_valids: got %b want %b", awl, wl, {AWVALID, WVALID}, (awl < wl) ? 2'b01 : 2'b10); else passed++;
    wait_valid(got, lat);
    take_rsp(rd, rs, to);
    ref_write(a, d, 4'hF);
    aw_lat = 1; w_lat = 1;
    total++; if (!got || rs !== 2'b00 || to !== 1'b0) $display("FAIL skew_%0d_%0d_rsp: got rs=%b to=%b want 00/0", awl, wl, rs, to); else passed++;
    total++; if (b_hs_n - b0 != 1 || aw_hs_n - a0 != 1 || w_hs_n - w0 != 1)
      $display("FAIL skew_%0d_%0d_hs_count: got b=%0d aw=%0d w=%0d want 1", awl, wl, b_hs_n - b0, aw_hs_n - a0, w_hs_n - w0); else passed++;
    total++; if (lat != 7) $display("FAIL skew_%0d_%0d_latency: got %0d want 7", awl, wl, lat); else passed++;
  endtask

  task automatic test_timeout();
    bit ok, got; int lat, arv_n; logic [31:0] rd; logic [1:0] rs; logic to;
    mon_en = 0; ar_never = 1; arv_n = 0; got = 0; lat = -1;
    issue(1'b0, 12'h020, 32'h0, 4'h0, ok);
    for (int i = 0; i < 40; i++) begin
      if (ARVALID === 1'b1) arv_n++;
      if (rsp_valid === 1'b1) begin got = 1; lat = cyc - acc_cyc; break; end
      @(negedge clk);
    end
    total++; if (arv_n != 16) $display("FAIL to_arvalid_cycles: got %0d want 16", arv_n); else passed++;
    total++; if (!got || lat != 16) $display("FAIL to_latency: got %0d want 16", lat); else passed++;
    total++; if (ARVALID !== 1'b0) $display("FAIL to_arvalid_drop: got %b want 0", ARVALID); else passed++;
    take_rsp(rd, rs, to);
    total++; if (to !== 1'b1 || rs !== 2'b10 || rd !== 32'h0)
      $display("FAIL to_rsp: got to=%b rs=%b rd=%h want 1/10/0", to, rs, rd); else passed++;
    ar_never = 0; mon_en = 1;
    issue(1'b0, 12'h024, 32'h0, 4'h0, ok);
    wait_valid(got, lat);
    take_rsp(rd, rs, to);
    total++; if (!ok || !got || to !== 1'b0 || rd !== ref_mem[9])
      $display("FAIL to_next_cmd: got to=%b rd=%h want 0/%h", to, rd, ref_mem[9]); else passed++;
  endtask

  task automatic test_rsp_hold();
    bit ok, got; int lat; logic [31:0] rd0, rd; logic [1:0] rs0, rs; logic to0, to;
    logic [11:0] a;
    a = 12'($urandom_range(0, 63) * 4);
    bfm_rresp = 2'b10;
    issue(1'b0, a, 32'h0, 4'h0, ok);
    wait_valid(got, lat);
    rd0 = rsp_rdata; rs0 = rsp_resp; to0 = rsp_timeout;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_resp !== rs0 || rsp_timeout !== to0)
        $display("FAIL hold_stable_%0d: got v=%b rd=%h rs=%b want 1/%h/%b", i, rsp_valid, rsp_rdata, rsp_resp, rd0, rs0); else passed++;
      total++; if (cmd_ready !== 1'b0) $display("FAIL hold_cmd_ready_%0d: got %b want 0", i, cmd_ready); else passed++;
    end
    take_rsp(rd, rs, to);
    bfm_rresp = 2'b00;
    total++; if (!got || rs !== 2'b10 || rd !== ref_mem[a[11:2]] || to !== 1'b0)
      $display("FAIL hold_rresp: got rs=%b rd=%h want 10/%h", rs, rd, ref_mem[a[11:2]]); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok, got; int lat; logic [31:0] rd, d; logic [1:0] rs; logic to; logic [11:0] a;
    w_lat = 20; mon_en = 0;
    issue(1'b1, 12'h040, 32'h55AA55AA, 4'hF, ok);
    repeat (2) @(negedge clk);
    total++; if (WVALID !== 1'b1) $display("FAIL rstmid_wvalid_pre: got %b want 1", WVALID); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, rsp_valid, cmd_ready} !== 8'h0)
      $display("FAIL rstmid_outputs: got %b want 0", {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, rsp_valid, cmd_ready}); else passed++;
    reset = 1'b0; w_lat = 1; init_ref();
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", cmd_ready); else passed++;
    mon_en = 1;
    a = 12'($urandom_range(0, 63) * 4); d = $urandom;
    issue(1'b1, a, d, 4'h5, ok);
    wait_valid(got, lat);
    take_rsp(rd, rs, to);
    ref_write(a, d, 4'h5);
    total++; if (!ok || !got || lat != 4 || rs !== 2'b00 || to !== 1'b0)
      $display("FAIL rstmid_write: got lat=%0d rs=%b to=%b want 4/00/0", lat, rs, to); else passed++;
    issue(1'b0, a, 32'h0, 4'h0, ok);
    wait_valid(got, lat);
    take_rsp(rd, rs, to);
    total++; if (rd !== ref_mem[a[11:2]]) $display("FAIL rstmid_readback: got %h want %h", rd, ref_mem[a[11:2]]); else passed++;
  endtask

  task automatic test_random();
    bit ok, got, wr; int lat; logic [31:0] rd, d; logic [1:0] rs; logic to;
    logic [11:0] a; logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = 12'($urandom_range(0, 63) * 4); d = $urandom; s = 4'($urandom_range(1, 15));
      aw_lat = $urandom_range(1, 3); w_lat = $urandom_range(1, 3); ar_lat = $urandom_range(1, 3);
      issue(wr, a, d, s, ok);
      wait_valid(got, lat);
      total++; if (!ok || !got) $display("FAIL rand_%0d_handshake: ok=%b got=%b", n, ok, got); else passed++;
      if (ok && got) begin
        take_rsp(rd, rs, to);
        if (wr) begin
          ref_write(a, d, s);
          total++; if (rs !== 2'b00 || to !== 1'b0 || rd !== 32'h0 || aw_cap !== a)
            $display("FAIL rand_%0d_write: got rs=%b to=%b rd=%h aw=%h want 00/0/0/%h", n, rs, to, rd, aw_cap, a); else passed++;
        end else begin
          total++; if (rs !== 2'b00 || to !== 1'b0 || rd !== ref_mem[a[11:2]])
            $display("FAIL rand_%0d_read: got rs=%b to=%b rd=%h want 00/0/%h", n, rs, to, rd, ref_mem[a[11:2]]); else passed++;
        end
      end
    end
    aw_lat = 1; w_lat = 1; ar_lat = 1;
  endtask

  task automatic test_protocol();
    total++; if (viol != 0) $display("FAIL protocol_valid_hold: got %0d violations want 0", viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_skew(1, 4);
    test_write_skew(4, 1);
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
